fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter: RAM_WIDTH, default 8, data word width in bits.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the delivered-word counter.
REQ-003 Port: r_clk  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 Port: r_rst  input  1  asynchronous, active-high reset; asserting it clears all state immediately.
REQ-005 Port: rd_en  input  1  enable; 0 = stop issuing new FIFO reads, in-flight and buffered words still drain.
REQ-006 Port: r_empty  input  1  FIFO empty flag from the read-side controller.
REQ-007 Port: r_req  output  1  FIFO read request.
REQ-008 Port: r_data  input  RAM_WIDTH  FIFO read data, valid one r_clk cycle after an accepted read.
REQ-009 Port: m_valid  output  1  output stream word valid.
REQ-010 Port: m_ready  input  1  downstream ready.
REQ-011 Port: m_data  output  RAM_WIDTH  output stream word.
REQ-012 Port: occ  output  2  buffered-word count, 0..2.
REQ-013 Port: rd_count  output  CNT_WIDTH  number of words delivered on the output stream.

Function
REQ-014 FIFO read accepted at an edge where r_req=1 and r_empty=0; the block SHALL capture r_data at the next rising edge (1-cycle read latency) into a 2-entry buffer.
REQ-015 One-bit inflight register SHALL be 1 in the cycle after an accepted read, else 0.
REQ-016 pop = m_valid && m_ready.
REQ-017 r_req = rd_en && !r_empty && (occ + inflight - pop) < 2; combinational; never asserted while r_empty=1.
REQ-018 Buffer state machine: S0 (occ=0), S1 (occ=1), S2 (occ=2); push = inflight.
REQ-019 Transitions: S0 push->S1; S1 push&!pop->S2, !push&pop->S0, push&pop or idle->S1; S2 pop&!push->S1, pop&push->S2, no pop->S2.
REQ-020 Push in S2 without pop SHALL be impossible by REQ-017; assertion flags it as error in simulation.
REQ-021 m_valid = (occ != 0); m_data = oldest buffered word (head); order strictly FIFO.
REQ-022 m_data and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 Push into S0 with m_ready=1: word SHALL appear on m_data/m_valid the cycle after capture (no bypass; output registered).
REQ-024 Sustained throughput SHALL be one word per r_clk when r_empty=0, rd_en=1, m_ready=1 continuously.
REQ-025 rd_count SHALL increment by 1 on each pop, wrapping modulo 2^CNT_WIDTH.
REQ-026 rd_en deassertion SHALL not drop an in-flight word; it is captured and delivered.
REQ-027 r_empty rising in the same cycle as r_req SHALL cancel that read (no inflight set).

Reset
REQ-028 While r_rst=1: r_req=0, m_valid=0, m_data=0, occ=0, inflight=0, rd_count=0, state S0.
REQ-029 Reset mid-transfer SHALL discard buffered and in-flight words; first read after release SHALL occur no earlier than the first edge after r_rst falls.

Verification
REQ-030 Reset: r_rst pulsed high with r_empty=0, rd_en=1 -> r_req=0, m_valid=0, occ=0, rd_count=0 during pulse.
REQ-031 Streaming: FIFO model holds 0..17, m_ready=1 -> m_data sequence 0..17, one per cycle after 2-cycle startup, rd_count=18, r_req low once r_empty=1.
REQ-032 Backpressure: FIFO holds 0..7, m_ready=0 -> exactly 2 reads issued, occ=2, m_data=0 held; m_ready=1 -> 0..7 in order, no loss or duplicate.
REQ-033 Pause: rd_en dropped the cycle after a read is accepted -> that word still delivered, no further r_req until rd_en=1.
REQ-034 Empty boundary: single word 5 in FIFO, r_empty toggling -> exactly one read, m_data=5 once, rd_count=1.
REQ-035 Wrap: CNT_WIDTH=4, 17 words popped -> rd_count=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a FIFO read port (1-cycle read latency) into a
// valid/ready output stream. A two-entry skid buffer (head/tail) absorbs
// the read latency so a continuously ready sink gets one word per cycle.
module fifo_rd_stream #(
  parameter int RAM_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 rd_en,
  input  logic                 r_empty,
  output logic                 r_req,
  input  logic [RAM_WIDTH-1:0] r_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic [1:0]           occ,
  output logic [CNT_WIDTH-1:0] rd_count
);

  // Buffer occupancy states; the encoding equals the word count.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [RAM_WIDTH-1:0] head_q, head_d;
  logic [RAM_WIDTH-1:0] tail_q, tail_d;
  logic                 inflight_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 push;
  logic                 pop;
  logic [2:0]           level;

  // A word returned by the FIFO arrives the cycle after its read was accepted.
  assign push    = inflight_q;
  assign m_valid = (state_q != S0);
  assign pop     = m_valid && m_ready;
  assign occ     = state_q;
  assign m_data  = head_q;
  assign rd_count = cnt_q;

  // Words that will still be held after this edge; a new read only issues
  // when there is room for it, which keeps S2 from ever seeing a push.
  assign level = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign r_req = !r_rst && rd_en && !r_empty && (level < 3'd2);

  // Next-state logic for the head/tail buffer and the delivered-word counter.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    case (state_q)
      S0: begin
        if (push) begin
          head_d  = r_data;
          state_d = S1;
        end
      end
      S1: begin
        if (push && !pop) begin
          tail_d  = r_data;
          state_d = S2;
        end else if (push && pop) begin
          head_d  = r_data;
        end else if (pop) begin
          state_d = S0;
        end
      end
      S2: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = r_data;
          end else begin
            state_d = S1;
          end
        end
      end
      default: state_d = S0;
    endcase
  end

  // State registers; reset discards buffered and in-flight words at once.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      state_q    <= S0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= r_req;
      cnt_q      <= cnt_d;
    end
  end

  // A push into a full buffer without a pop would lose a word.
  a_no_overflow: assert property (@(posedge r_clk) disable iff (r_rst)
    !(state_q == S2 && push && !pop));

endmodule
